// File: rtl/memory_responder.sv
// Word-organised RAM answering controller read/write strobes with a fixed
// READ_LATENCY read pipeline, sticky out-of-range error and saturating counters.
module memory_responder #(
   parameter int          CLK_FREQ     = 25000000,
   parameter int          MEMORY_SIZE  = 4096,
   parameter string       MEMORY_FILE  = "",
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] ERROR_DATA   = 32'h00000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memory_read_memory,
   input  logic        memory_write_memory,
   input  logic [31:0] address_memory,
   input  logic [31:0] write_data_memory,
   output logic [31:0] read_data,
   output logic        read_valid,
   output logic        error,
   input  logic        clear_error,
   output logic [31:0] read_count,
   output logic [31:0] write_count
);

   localparam int BYTE_W = $clog2(MEMORY_SIZE);
   localparam int DEPTH  = MEMORY_SIZE / 4;
   localparam int IDX_W  = (BYTE_W > 2) ? BYTE_W - 2 : 1;

   logic [31:0]            r_mem [DEPTH];
   logic [READ_LATENCY:1]  r_vld_pipe;
   logic [31:0]            r_dat_pipe [1:READ_LATENCY];
   logic                   r_err;
   logic [31:0]            r_rd_cnt;
   logic [31:0]            r_wr_cnt;

   logic [IDX_W-1:0]       w_idx;
   logic                   w_in_range;
   logic                   w_bad;
   logic [31:0]            w_rd_word;

   assign w_idx      = address_memory[IDX_W+1:2];
   assign w_in_range = (address_memory >> BYTE_W) == 32'd0;
   assign w_bad      = (memory_read_memory | memory_write_memory) & ~w_in_range;

   // Write-first: a read sharing the cycle with a write sees the new word.
   assign w_rd_word = !w_in_range         ? ERROR_DATA :
                      memory_write_memory ? write_data_memory :
                                            r_mem[w_idx];

   // RAM is deliberately outside the reset domain so images survive reset.
   always_ff @(posedge clk) begin
      if (memory_write_memory && w_in_range)
         r_mem[w_idx] <= write_data_memory;
   end

   // Data stages only advance behind a valid so read_data holds between pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vld_pipe <= '0;
         for (int k = 1; k <= READ_LATENCY; k++) r_dat_pipe[k] <= '0;
      end else begin
         r_vld_pipe[1] <= memory_read_memory;
         if (memory_read_memory) r_dat_pipe[1] <= w_rd_word;
         for (int k = 2; k <= READ_LATENCY; k++) begin
            r_vld_pipe[k] <= r_vld_pipe[k-1];
            if (r_vld_pipe[k-1]) r_dat_pipe[k] <= r_dat_pipe[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_err    <= 1'b0;
         r_rd_cnt <= '0;
         r_wr_cnt <= '0;
      end else begin
         if (w_bad)            r_err <= 1'b1;
         else if (clear_error) r_err <= 1'b0;
         if (memory_read_memory && r_rd_cnt != 32'hFFFFFFFF)
            r_rd_cnt <= r_rd_cnt + 32'd1;
         if (memory_write_memory && r_wr_cnt != 32'hFFFFFFFF)
            r_wr_cnt <= r_wr_cnt + 32'd1;
      end
   end

   assign read_valid  = r_vld_pipe[READ_LATENCY];
   assign read_data   = r_dat_pipe[READ_LATENCY];
   assign error       = r_err;
   assign read_count  = r_rd_cnt;
   assign write_count = r_wr_cnt;

endmodule

// File: tb/tb_memory_responder.sv
// Three responders (latency 1..3) share one stimulus stream and are checked
// against a queue-based model of the memory and response timing.
module tb_memory_responder;
   localparam int          MSIZE = 4096;
   localparam int          DEPTH = MSIZE / 4;
   localparam logic [31:0] ERRD  = 32'hDEADBEEF;

   typedef struct {
      int unsigned due;
      logic [31:0] data;
   } resp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rd = 1'b0, wr = 1'b0, clr = 1'b0;
   logic [31:0] addr = '0, wdata = '0;

   logic [2:0][31:0] o_data, o_rcnt, o_wcnt;
   logic [2:0]       o_vld, o_err;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gen_dut
      memory_responder #(
         .MEMORY_SIZE (MSIZE),
         .READ_LATENCY(g + 1),
         .ERROR_DATA  (ERRD)
      ) u_dut (
         .clk                (clk),
         .reset              (reset),
         .memory_read_memory (rd),
         .memory_write_memory(wr),
         .address_memory     (addr),
         .write_data_memory  (wdata),
         .read_data          (o_data[g]),
         .read_valid         (o_vld[g]),
         .error              (o_err[g]),
         .clear_error        (clr),
         .read_count         (o_rcnt[g]),
         .write_count        (o_wcnt[g])
      );
   end

   // reference model
   logic [31:0] m_mem [DEPTH];
   resp_t       rq [3][$];
   logic [31:0] m_data [3];
   logic        m_vld [3];
   logic        m_err;
   logic [31:0] m_rcnt, m_wcnt;
   int unsigned edge_no = 0;

   int total = 0;
   int bad   = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_no);
      end
   endtask

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         rq[k].delete();
         m_data[k] = '0;
         m_vld[k]  = 1'b0;
      end
      m_err  = 1'b0;
      m_rcnt = '0;
      m_wcnt = '0;
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("L%0d_valid", k+1), {31'd0, o_vld[k]}, {31'd0, m_vld[k]});
         chk($sformatf("L%0d_data",  k+1), o_data[k], m_data[k]);
         chk($sformatf("L%0d_error", k+1), {31'd0, o_err[k]}, {31'd0, m_err});
         chk($sformatf("L%0d_rcnt",  k+1), o_rcnt[k], m_rcnt);
         chk($sformatf("L%0d_wcnt",  k+1), o_wcnt[k], m_wcnt);
      end
   endtask

   // One rising edge with the currently driven inputs, then model update and check.
   task automatic cyc();
      logic        inr;
      logic [31:0] word;
      @(posedge clk);
      edge_no++;
      if (!reset) begin
         model_clear();
      end else begin
         inr  = addr < MSIZE;
         word = !inr ? ERRD : (wr ? wdata : m_mem[addr[11:2]]);
         if (wr && inr) m_mem[addr[11:2]] = wdata;
         if (rd)
            for (int k = 0; k < 3; k++)
               rq[k].push_back('{due: edge_no + k, data: word});
         if ((rd || wr) && !inr) m_err = 1'b1;
         else if (clr)           m_err = 1'b0;
         if (rd && m_rcnt != 32'hFFFFFFFF) m_rcnt++;
         if (wr && m_wcnt != 32'hFFFFFFFF) m_wcnt++;
         for (int k = 0; k < 3; k++) begin
            m_vld[k] = 1'b0;
            if (rq[k].size() > 0 && rq[k][0].due == edge_no) begin
               m_vld[k]  = 1'b1;
               m_data[k] = rq[k][0].data;
               void'(rq[k].pop_front());
            end
         end
      end
      #1;
      check_all();
   endtask

   task automatic drive(logic r, logic w, logic c, logic [31:0] a, logic [31:0] d);
      @(negedge clk);
      rd = r; wr = w; clr = c; addr = a; wdata = d;
      cyc();
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      rd = 1'b0; wr = 1'b0; clr = 1'b0;
      model_clear();
      #1;
      check_all();
      cyc();
      cyc();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      model_clear();
      #2 reset = 1'b0;
      #1 check_all();
      @(negedge clk);
      reset = 1'b1;

      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'hCAFEBABE);
      drive(1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
      idle(3);

      drive(1'b0, 1'b1, 1'b0, 32'h0, 32'd1);
      drive(1'b0, 1'b1, 1'b0, 32'h4, 32'd2);
      drive(1'b0, 1'b1, 1'b0, 32'h8, 32'd3);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'h4, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'h8, 32'd0);
      idle(4);

      drive(1'b0, 1'b1, 1'b0, 32'h20, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h12345678);
      idle(4);

      drive(1'b0, 1'b1, 1'b0, 32'h1000, 32'h55555555);
      idle(1);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
      idle(3);
      drive(1'b1, 1'b0, 1'b0, 32'h2000, 32'd0);
      idle(3);
      drive(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      idle(1);
      drive(1'b0, 1'b1, 1'b1, 32'h1000, 32'd7);
      idle(1);
      drive(1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
      idle(1);

      // reset one cycle after a read strobe: nothing may come back
      drive(1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
      idle(4);

      for (int i = 0; i < DEPTH; i++)
         drive(1'b0, 1'b1, 1'b0, i * 4, $urandom);

      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 9) == 0) ? $urandom_range(4*MSIZE-1, MSIZE)
                                         : $urandom_range(MSIZE-1, 0);
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 7) == 0), a, $urandom);
      end
      idle(4);

      @(negedge clk);
      force gen_dut[0].u_dut.r_wr_cnt = 32'hFFFFFFFE;
      force gen_dut[1].u_dut.r_wr_cnt = 32'hFFFFFFFE;
      force gen_dut[2].u_dut.r_wr_cnt = 32'hFFFFFFFE;
      #1;
      release gen_dut[0].u_dut.r_wr_cnt;
      release gen_dut[1].u_dut.r_wr_cnt;
      release gen_dut[2].u_dut.r_wr_cnt;
      m_wcnt = 32'hFFFFFFFE;
      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'b1, 1'b0, 32'h40, $urandom);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
